// File: rtl/frame_read_arbiter.sv
// frame_read_arbiter
//   Routes the frame-buffer read port to one of N_CH image consumers. The
//   owning channel is chosen from a synchronised, debounced sel input and can
//   only change between frames. After each frame (or an aborted one) the SDRAM
//   read address is rewound and the owning channel gets a frame_done pulse.
//   A read that stalls for TIMEOUT cycles aborts the frame and sets a sticky
//   timeout_err.
// Ports
//   clk, rst         clock; asynchronous active-low reset
//   sel              requested channel (asynchronous source)
//   sdram_dout       pixel read data
//   sdram_rd_vld     one pixel per high cycle
//   sdram_ready      a full frame is available (level)
//   sdram_rd_req     read request, follows the owning channel's request
//   sdram_clr_addr   1-cycle rewind pulse at the end of a frame
//   ch_din           pixel data shared by all channels (zero outside a frame)
//   ch_en            one-hot owner of the frame in progress
//   ch_rd_req        per-channel read requests
//   ch_rd_ack        per-channel data-valid strobes
//   ch_frame_done    1-cycle pulse to the owner when the frame ends
//   active_ch        index of the granted channel
//   timeout_err      sticky stall flag, cleared only by reset
module frame_read_arbiter #(
  parameter int N_CH         = 2,
  parameter int DW           = 16,
  parameter int FRAME_PIXELS = 76800,
  parameter int SEL_STABLE   = 4,
  parameter int TIMEOUT      = 1024,
  localparam int SELW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SELW-1:0] sel,
  input  logic [DW-1:0]   sdram_dout,
  input  logic            sdram_rd_vld,
  input  logic            sdram_ready,
  output logic            sdram_rd_req,
  output logic            sdram_clr_addr,
  output logic [DW-1:0]   ch_din,
  output logic [N_CH-1:0] ch_en,
  input  logic [N_CH-1:0] ch_rd_req,
  output logic [N_CH-1:0] ch_rd_ack,
  output logic [N_CH-1:0] ch_frame_done,
  output logic [SELW-1:0] active_ch,
  output logic            timeout_err
);

  localparam int CNTW  = $clog2(FRAME_PIXELS);
  localparam int WAITW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int STBW  = $clog2(SEL_STABLE + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  localparam logic [N_CH-1:0] ONE_HOT0 = {{(N_CH-1){1'b0}}, 1'b1};

  // sel synchroniser and debounce
  logic [SELW-1:0] sync1_q, sync2_q;
  logic [SELW-1:0] cand_q, cand_d;
  logic [STBW-1:0] hold_q, hold_d;
  logic [SELW-1:0] sel_q, sel_d;

  // frame control
  logic [1:0]       state_q, state_d;
  logic [SELW-1:0]  active_q, active_d;
  logic [CNTW-1:0]  pix_q, pix_d;
  logic [WAITW-1:0] wait_q, wait_d;
  logic             err_q, err_d;

  logic             req_act;
  logic [N_CH-1:0]  owner_oh;

  // hold_q counts consecutive cycles the synced value has matched cand_q,
  // including the current one, saturating at SEL_STABLE. Out-of-range
  // requests never reach sel_q.
  always_comb begin
    cand_d = sync2_q;
    if (sync2_q == cand_q) begin
      hold_d = (hold_q == STBW'(SEL_STABLE)) ? hold_q : hold_q + STBW'(1);
    end else begin
      hold_d = STBW'(1);
    end
    sel_d = sel_q;
    if (hold_d == STBW'(SEL_STABLE) && int'(sync2_q) < N_CH) begin
      sel_d = sync2_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      hold_q  <= '0;
      sel_q   <= '0;
    end else begin
      sync1_q <= sel;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      hold_q  <= hold_d;
      sel_q   <= sel_d;
    end
  end

  assign req_act  = ch_rd_req[active_q];
  assign owner_oh = ONE_HOT0 << active_q;

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    pix_d    = pix_q;
    wait_d   = wait_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        active_d = sel_q;
        wait_d   = '0;
        if (sdram_ready) begin
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        // a vld on the expiry cycle wins over the timeout
        if (sdram_rd_vld) begin
          pix_d  = pix_q + CNTW'(1);
          wait_d = '0;
          if (pix_q == CNTW'(FRAME_PIXELS - 1)) begin
            state_d = S_CLEAR;
          end
        end else if (req_act) begin
          if (wait_q == WAITW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            wait_d  = '0;
            state_d = S_CLEAR;
          end else begin
            wait_d = wait_q + WAITW'(1);
          end
        end else begin
          wait_d = '0;
        end
      end
      S_CLEAR: begin
        pix_d   = '0;
        wait_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      active_q <= '0;
      pix_q    <= '0;
      wait_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      pix_q    <= pix_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    sdram_rd_req   = 1'b0;
    sdram_clr_addr = 1'b0;
    ch_din         = '0;
    ch_en          = '0;
    ch_rd_ack      = '0;
    ch_frame_done  = '0;
    if (state_q == S_GRANT) begin
      sdram_rd_req = req_act;
      ch_din       = sdram_dout;
      ch_en        = owner_oh;
      ch_rd_ack    = sdram_rd_vld ? owner_oh : '0;
    end
    if (state_q == S_CLEAR) begin
      sdram_clr_addr = 1'b1;
      ch_frame_done  = owner_oh;
    end
  end

  assign active_ch   = active_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_frame_read_arbiter.sv
// tb_frame_read_arbiter
//   Directed and randomised stimulus for frame_read_arbiter (3 channels, short
//   frames, short timeout) checked every cycle against a behavioural model.
module tb_frame_read_arbiter;

  localparam int N_CH = 3;
  localparam int DW   = 16;
  localparam int FP   = 16;
  localparam int SS   = 4;
  localparam int TO   = 32;

  localparam int P_IDLE  = 0;
  localparam int P_GRANT = 1;
  localparam int P_CLEAR = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    sel = '0;
  logic [DW-1:0] sdram_dout = '0;
  logic          sdram_rd_vld = 1'b0;
  logic          sdram_ready = 1'b0;
  logic          sdram_rd_req;
  logic          sdram_clr_addr;
  logic [DW-1:0] ch_din;
  logic [2:0]    ch_en;
  logic [2:0]    ch_rd_req = '0;
  logic [2:0]    ch_rd_ack;
  logic [2:0]    ch_frame_done;
  logic [1:0]    active_ch;
  logic          timeout_err;

  frame_read_arbiter #(
    .N_CH(N_CH), .DW(DW), .FRAME_PIXELS(FP), .SEL_STABLE(SS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel), .sdram_dout(sdram_dout),
    .sdram_rd_vld(sdram_rd_vld), .sdram_ready(sdram_ready),
    .sdram_rd_req(sdram_rd_req), .sdram_clr_addr(sdram_clr_addr),
    .ch_din(ch_din), .ch_en(ch_en), .ch_rd_req(ch_rd_req),
    .ch_rd_ack(ch_rd_ack), .ch_frame_done(ch_frame_done),
    .active_ch(active_ch), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // behavioural model
  int   syn_pipe[$];
  int   win[$];
  int   m_selq, m_phase, m_pix, m_stall;
  logic [1:0] m_active;
  logic m_err;

  // observed-event counters
  int n_ack[3];
  int n_done[3];
  int n_clr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    syn_pipe = '{0, 0};
    win.delete();
    m_selq = 0; m_phase = P_IDLE; m_pix = 0; m_stall = 0;
    m_active = '0; m_err = 1'b0;
  endtask

  task automatic model_edge();
    int syn;
    int nsel;
    bit same;
    // sel seen by the filter lags the pin by two clocks
    syn = syn_pipe[0];
    void'(syn_pipe.pop_front());
    syn_pipe.push_back(int'(sel));
    win.push_back(syn);
    if (win.size() > SS) void'(win.pop_front());
    nsel = m_selq;
    if (win.size() == SS) begin
      same = 1'b1;
      foreach (win[i]) if (win[i] != syn) same = 1'b0;
      if (same && syn < N_CH) nsel = syn;
    end
    case (m_phase)
      P_IDLE: begin
        m_active = 2'(m_selq);
        if (sdram_ready) m_phase = P_GRANT;
      end
      P_GRANT: begin
        if (sdram_rd_vld) begin
          m_pix++;
          m_stall = 0;
          if (m_pix == FP) m_phase = P_CLEAR;
        end else if (ch_rd_req[m_active]) begin
          m_stall++;
          if (m_stall == TO) begin
            m_err = 1'b1;
            m_phase = P_CLEAR;
          end
        end else begin
          m_stall = 0;
        end
      end
      default: begin
        m_pix = 0;
        m_stall = 0;
        m_phase = P_IDLE;
      end
    endcase
    m_selq = nsel;
  endtask

  task automatic check_all(input string tag);
    logic [2:0] oh, e_en, e_ack, e_done;
    logic e_req, e_clr;
    logic [DW-1:0] e_din;
    oh     = 3'b001 << m_active;
    e_en   = (m_phase == P_GRANT) ? oh : 3'b000;
    e_req  = (m_phase == P_GRANT) ? ch_rd_req[m_active] : 1'b0;
    e_ack  = (m_phase == P_GRANT && sdram_rd_vld) ? oh : 3'b000;
    e_din  = (m_phase == P_GRANT) ? sdram_dout : '0;
    e_clr  = (m_phase == P_CLEAR);
    e_done = (m_phase == P_CLEAR) ? oh : 3'b000;
    chk({tag, ".ch_en"},     32'(ch_en),          32'(e_en));
    chk({tag, ".rd_req"},    32'(sdram_rd_req),   32'(e_req));
    chk({tag, ".ack"},       32'(ch_rd_ack),      32'(e_ack));
    chk({tag, ".din"},       32'(ch_din),         32'(e_din));
    chk({tag, ".clr"},       32'(sdram_clr_addr), 32'(e_clr));
    chk({tag, ".done"},      32'(ch_frame_done),  32'(e_done));
    chk({tag, ".active"},    32'(active_ch),      32'(m_active));
    chk({tag, ".timeout"},   32'(timeout_err),    32'(m_err));
  endtask

  // called at a negedge with inputs already set; returns at the next negedge
  task automatic tick(input string tag);
    #1;
    check_all(tag);
    for (int i = 0; i < 3; i++) begin
      if (ch_rd_ack[i]) n_ack[i]++;
      if (ch_frame_done[i]) n_done[i]++;
    end
    if (sdram_clr_addr) n_clr++;
    @(posedge clk);
    if (!rst) model_reset(); else model_edge();
    @(negedge clk);
  endtask

  task automatic cyc(input string tag, input logic [1:0] s, input logic rdy,
                     input logic [2:0] rq, input logic v);
    sel = s; sdram_ready = rdy; ch_rd_req = rq; sdram_rd_vld = v;
    sdram_dout = DW'($urandom);
    tick(tag);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 3; i++) begin n_ack[i] = 0; n_done[i] = 0; end
    n_clr = 0;
  endtask

  initial begin
    int guard;
    logic [1:0] rs;
    model_reset();
    clear_counts();
    #1;
    check_all("reset");
    @(negedge clk);
    cyc("reset_hold", 2'd0, 1'b0, 3'b000, 1'b0);
    rst = 1'b1;

    // single frame on channel 1; ready dropping mid-frame is ignored
    for (int i = 0; i < 10; i++) cyc("t1_sel", 2'd1, 1'b0, 3'b000, 1'b0);
    clear_counts();
    cyc("t1_start", 2'd1, 1'b1, 3'b010, 1'b0);
    guard = 0;
    while (n_ack[1] < FP && guard < 200) begin
      cyc("t1_frame", 2'd1, 1'b0, 3'b010, 1'($urandom_range(0, 3) != 0));
      guard++;
    end
    for (int i = 0; i < 4; i++) cyc("t1_tail", 2'd1, 1'b0, 3'b010, 1'b0);
    chk("t1_acks_ch1", 32'(n_ack[1]), 32'(FP));
    chk("t1_acks_ch0", 32'(n_ack[0]), 32'd0);
    chk("t1_done_ch1", 32'(n_done[1]), 32'd1);
    chk("t1_clr", 32'(n_clr), 32'd1);

    // sel change at pixel 5 is deferred to the next frame
    for (int i = 0; i < 10; i++) cyc("t2_sel", 2'd0, 1'b0, 3'b000, 1'b0);
    clear_counts();
    cyc("t2_start", 2'd0, 1'b1, 3'b011, 1'b0);
    for (int i = 0; i < 5; i++) cyc("t2_a", 2'd0, 1'b0, 3'b011, 1'b1);
    for (int i = 0; i < FP - 5; i++) cyc("t2_b", 2'd1, 1'b0, 3'b011, 1'b1);
    cyc("t2_end", 2'd1, 1'b0, 3'b011, 1'b0);
    chk("t2_acks_ch0", 32'(n_ack[0]), 32'(FP));
    chk("t2_acks_ch1", 32'(n_ack[1]), 32'd0);
    cyc("t2_next", 2'd1, 1'b1, 3'b010, 1'b0);
    cyc("t2_next_g", 2'd1, 1'b0, 3'b010, 1'b0);
    chk("t2_next_ch", 32'(active_ch), 32'd1);
    for (int i = 0; i < FP + 2; i++) cyc("t2_next_f", 2'd1, 1'b0, 3'b010, 1'(i < FP));

    // 3-cycle glitch is filtered out
    for (int i = 0; i < 10; i++) cyc("t3_sel0", 2'd0, 1'b0, 3'b000, 1'b1);
    chk("t3_pre", 32'(active_ch), 32'd0);
    for (int i = 0; i < 3; i++) cyc("t3_glitch", 2'd1, 1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 10; i++) cyc("t3_after", 2'd0, 1'b0, 3'b000, 1'b0);
    chk("t3_active", 32'(active_ch), 32'd0);

    // vld on the last allowed stall cycle keeps the frame alive
    cyc("t4a_start", 2'd0, 1'b1, 3'b001, 1'b0);
    for (int i = 0; i < TO - 1; i++) cyc("t4a_stall", 2'd0, 1'b0, 3'b001, 1'b0);
    for (int i = 0; i < FP; i++) cyc("t4a_data", 2'd0, 1'b0, 3'b001, 1'b1);
    cyc("t4a_end", 2'd0, 1'b0, 3'b001, 1'b0);
    chk("t4a_no_timeout", 32'(timeout_err), 32'd0);

    // full stall aborts the frame
    clear_counts();
    cyc("t4_start", 2'd0, 1'b1, 3'b001, 1'b0);
    for (int i = 0; i < TO + 8; i++) cyc("t4_stall", 2'd0, 1'b0, 3'b001, 1'b0);
    chk("t4_timeout", 32'(timeout_err), 32'd1);
    chk("t4_clr", 32'(n_clr), 32'd1);
    chk("t4_done", 32'(n_done[0]), 32'd1);
    chk("t4_idle_en", 32'(ch_en), 32'd0);

    // out-of-range sel is ignored
    for (int i = 0; i < 10; i++) cyc("t5_sel2", 2'd2, 1'b0, 3'b000, 1'b0);
    chk("t5_sel2", 32'(active_ch), 32'd2);
    for (int i = 0; i < 12; i++) cyc("t5_sel3", 2'd3, 1'b0, 3'b000, 1'b0);
    chk("t5_sel3", 32'(active_ch), 32'd2);

    // random traffic
    rs = 2'd0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) rs = 2'($urandom_range(0, 3));
      cyc("rand", rs, 1'($urandom_range(0, 3) == 0), 3'($urandom),
          1'($urandom_range(0, 1)));
    end

    // asynchronous reset in the middle of a frame
    guard = 0;
    while (m_phase != P_GRANT && guard < 100) begin
      cyc("t6_wait", 2'd1, 1'b1, 3'b111, 1'b0);
      guard++;
    end
    chk("t6_in_grant", 32'(ch_en != 3'b000), 32'd1);
    sdram_rd_vld = 1'b1;
    ch_rd_req = 3'b111;
    sdram_dout = 16'hA5A5;
    #1;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("t6_rst");
    chk("t6_ack_zero", 32'(ch_rd_ack), 32'd0);
    @(negedge clk);
    cyc("t6_hold", 2'd1, 1'b1, 3'b111, 1'b1);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) cyc("t6_after", 2'd1, 1'b0, 3'b000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
